// File: rtl/alu_pkg.sv
// alu_pkg: command encodings, command limits, issue states and the entry control fields shared by the ALU1 issue path.
package alu_pkg;
    localparam logic [3:0] CMD_MUL_INC   = 4'd9;
    localparam logic [3:0] CMD_MUL_SHL   = 4'd10;
    localparam logic [3:0] ARITH_CMD_MAX = 4'd10;
    localparam logic [3:0] LOGIC_CMD_MAX = 4'd13;
    typedef enum logic [1:0] {IDLE, ISSUE, MUL_WAIT} issue_state_t;
    typedef struct packed {
        logic       cin;
        logic [3:0] cmd;
        logic       mode;
        logic [1:0] opvalid;
    } alu_op_t;
    function automatic logic is_mul_cmd(input logic mode, input logic [3:0] cmd);
        return mode && (cmd == CMD_MUL_INC || cmd == CMD_MUL_SHL);
    endfunction
endpackage

// File: rtl/alu_op_fifo.sv
// alu_op_fifo: synchronous FIFO with push/pop/flush, occupancy count and full/empty flags.
module alu_op_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rp];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= din;
                wp      <= wp + 1'b1;
            end
            if (do_pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: buffers ALU ops and issues them to ALU1 with registered outputs and bubbles after multiplies.
// Optional push-side legality check with DROP/DROP_CNT outputs: define ALU_ISSUE_CHECK_EN.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int INPUT   = 8,
    parameter int DEPTH   = 4,
    parameter int MUL_GAP = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [INPUT-1:0] IN_OPA,
    input  logic [INPUT-1:0] IN_OPB,
    input  logic             IN_CIN,
    input  logic [3:0]       IN_CMD,
    input  logic             IN_MODE,
    input  logic [1:0]       IN_OPVALID,
    output logic [INPUT-1:0] OPA,
    output logic [INPUT-1:0] OPB,
    output logic             CIN,
    output logic             MODE,
    output logic [3:0]       CMD,
    output logic [1:0]       VALID,
    output logic             CE,
    output logic [15:0]      ISSUE_CNT
`ifdef ALU_ISSUE_CHECK_EN
    ,
    output logic             DROP,
    output logic [7:0]       DROP_CNT
`endif
);
    typedef struct packed {
        logic [INPUT-1:0] opa;
        logic [INPUT-1:0] opb;
        alu_op_t          ctl;
    } entry_t;
    entry_t in_e, head;
    issue_state_t state;
    logic [$clog2(DEPTH):0] count;
    logic [1:0] gap;
    logic full, empty, legal, mul_hold, advance, pop;
    assign in_e = '{opa: IN_OPA, opb: IN_OPB,
                    ctl: '{cin: IN_CIN, cmd: IN_CMD, mode: IN_MODE, opvalid: IN_OPVALID}};
    assign IN_READY = count != ($clog2(DEPTH)+1)'(DEPTH);
`ifdef ALU_ISSUE_CHECK_EN
    assign legal = IN_OPVALID != 2'b00 && (IN_MODE ? IN_CMD <= ARITH_CMD_MAX : IN_CMD <= LOGIC_CMD_MAX);
`else
    assign legal = 1'b1;
`endif
    alu_op_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .flush (FLUSH),
        .push  (IN_VALID && !full && legal),
        .pop   (pop),
        .din   (in_e),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );
    // decisions are made on the op currently held in the output registers
    assign mul_hold = MUL_GAP > 0 && is_mul_cmd(MODE, CMD);
    assign advance  = state == IDLE || (state == ISSUE && !mul_hold) || (state == MUL_WAIT && gap == '0);
    assign pop      = !FLUSH && !empty && advance;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            gap       <= '0;
            CE        <= 1'b0;
            OPA       <= '0;
            OPB       <= '0;
            CIN       <= 1'b0;
            CMD       <= '0;
            MODE      <= 1'b0;
            VALID     <= '0;
            ISSUE_CNT <= '0;
        end else if (FLUSH) begin
            state <= IDLE;
            CE    <= 1'b0;
        end else if (pop) begin
            state     <= ISSUE;
            CE        <= 1'b1;
            OPA       <= head.opa;
            OPB       <= head.opb;
            CIN       <= head.ctl.cin;
            CMD       <= head.ctl.cmd;
            MODE      <= head.ctl.mode;
            VALID     <= head.ctl.opvalid;
            ISSUE_CNT <= ISSUE_CNT + 16'd1;
        end else if (state == ISSUE && mul_hold) begin
            state <= MUL_WAIT;
            gap   <= 2'(MUL_GAP - 1);
            CE    <= 1'b0;
        end else if (state == MUL_WAIT && gap != '0) begin
            gap <= gap - 2'd1;
            CE  <= 1'b0;
        end else begin
            state <= IDLE;
            CE    <= 1'b0;
        end
    end
`ifdef ALU_ISSUE_CHECK_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            DROP     <= 1'b0;
            DROP_CNT <= '0;
        end else begin
            DROP <= IN_VALID && IN_READY && !legal;
            if (IN_VALID && IN_READY && !legal && DROP_CNT != 8'hFF) DROP_CNT <= DROP_CNT + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: vector table, directed corner sequences and a randomized scoreboard run for alu_issue_ctrl.
module tb_alu_issue_ctrl;
    localparam int DEPTH = 4, MUL_GAP = 1;
    typedef struct packed {
        logic [7:0] opa;
        logic [7:0] opb;
        logic       cin;
        logic [3:0] cmd;
        logic       mode;
        logic [1:0] ov;
    } op_s;
    typedef struct {
        op_s op;
        int  bubble;
    } vec_t;
    logic CLK = 0, RST = 1, FLUSH = 0, IN_VALID = 0, IN_CIN = 0, IN_MODE = 0;
    logic [7:0] IN_OPA = '0, IN_OPB = '0;
    logic [3:0] IN_CMD = '0;
    logic [1:0] IN_OPVALID = '0;
    logic IN_READY, CIN, MODE, CE;
    logic [7:0] OPA, OPB;
    logic [3:0] CMD;
    logic [1:0] VALID;
    logic [15:0] ISSUE_CNT;
`ifdef ALU_ISSUE_CHECK_EN
    logic DROP;
    logic [7:0] DROP_CNT;
`endif
    int tests = 0, fails = 0;
    alu_issue_ctrl #(.INPUT(8), .DEPTH(DEPTH), .MUL_GAP(MUL_GAP)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_OPA(IN_OPA), .IN_OPB(IN_OPB), .IN_CIN(IN_CIN), .IN_CMD(IN_CMD), .IN_MODE(IN_MODE),
        .IN_OPVALID(IN_OPVALID), .OPA(OPA), .OPB(OPB), .CIN(CIN), .MODE(MODE), .CMD(CMD),
        .VALID(VALID), .CE(CE), .ISSUE_CNT(ISSUE_CNT)
`ifdef ALU_ISSUE_CHECK_EN
        , .DROP(DROP), .DROP_CNT(DROP_CNT)
`endif
    );
    always #5 CLK = ~CLK;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask
    task automatic drive(input op_s o, input logic v);
        IN_OPA = o.opa; IN_OPB = o.opb; IN_CIN = o.cin;
        IN_CMD = o.cmd; IN_MODE = o.mode; IN_OPVALID = o.ov; IN_VALID = v;
    endtask
    function automatic op_s mk(input logic [7:0] a, input logic [7:0] b, input logic c,
                               input logic [3:0] cmd, input logic m, input logic [1:0] ov);
        return '{opa: a, opb: b, cin: c, cmd: cmd, mode: m, ov: ov};
    endfunction
    function automatic op_s cur();
        return '{opa: OPA, opb: OPB, cin: CIN, cmd: CMD, mode: MODE, ov: VALID};
    endfunction
    function automatic op_s rand_op();
        op_s o;
        o.opa  = 8'($urandom);
        o.opb  = 8'($urandom);
        o.cin  = 1'($urandom);
        o.mode = 1'($urandom);
        o.cmd  = o.mode ? 4'($urandom_range(0, 10)) : 4'($urandom_range(0, 13));
        if (o.mode && $urandom_range(0, 2) == 0) o.cmd = 4'($urandom_range(9, 10));
        o.ov   = 2'($urandom_range(1, 3));
        return o;
    endfunction
    vec_t vecs[6];
    op_s filler, nop, e, r, last;
    op_s q[$];
    int exp_cnt, g, n, avail, owe, bl;
    logic saw, pushed, fl, v, pushing;
    initial begin
        vecs[0] = '{mk(8'hFF, 8'h00, 0, 4'd4, 1, 2'b01), 0};
        vecs[1] = '{mk(8'd64, 8'd63, 0, 4'd9, 1, 2'b11), 1};
        vecs[2] = '{mk(8'h01, 8'h02, 1, 4'd10, 1, 2'b10), 1};
        vecs[3] = '{mk(8'h09, 8'h09, 0, 4'd9, 0, 2'b01), 0};
        vecs[4] = '{mk(8'hAA, 8'h55, 1, 4'd13, 0, 2'b11), 0};
        vecs[5] = '{mk(8'h07, 8'h08, 0, 4'd10, 0, 2'b11), 0};
        filler = mk(8'h11, 8'h22, 0, 4'd0, 0, 2'b11);
        nop = '0;
        // reset state
        tick(); tick();
        chk("rst_out", 32'(cur()), 32'(0));
        chk("rst_ce", CE, 0);
        chk("rst_cnt", ISSUE_CNT, 0);
        chk("rst_ready", IN_READY, 1);
        RST = 0;
        exp_cnt = 0;
        // single op latency: issue one cycle after the push edge is sampled
        drive(mk(8'hFF, 8'h00, 0, 4'd4, 1, 2'b01), 1);
        tick();
        drive(nop, 0);
        chk("lat_ce_early", CE, 0);
        tick();
        exp_cnt++;
        chk("lat_ce", CE, 1);
        chk("lat_out", 32'(cur()), 32'(mk(8'hFF, 8'h00, 0, 4'd4, 1, 2'b01)));
        chk("lat_cnt", ISSUE_CNT, exp_cnt);
        tick();
        chk("lat_ce_off", CE, 0);
        chk("lat_hold", OPA, 8'hFF);
        // vector table: op followed by a filler, measuring the bubble between them
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].op, 1);
            tick();
            drive(filler, 1);
            tick();
            drive(nop, 0);
            chk("vec_ce", CE, 1);
            chk("vec_out", 32'(cur()), 32'(vecs[i].op));
            tick();
            g = 0;
            while (!CE && g < 6) begin
                chk("vec_bubble_hold", 32'(cur()), 32'(vecs[i].op));
                g++;
                tick();
            end
            chk("vec_gap", g, vecs[i].bubble);
            chk("vec_filler", 32'(cur()), 32'(filler));
            exp_cnt += 2;
            chk("vec_cnt", ISSUE_CNT, exp_cnt);
            tick(); tick();
        end
        // five back-to-back ops issue on consecutive cycles
        for (int i = 0; i < 7; i++) begin
            if (i < 5) begin
                chk("b2b_ready", IN_READY, 1);
                drive(mk(8'h50 + 8'(i), 8'hA0 + 8'(i), 1'(i), 4'(i), 0, 2'b10), 1);
            end else drive(nop, 0);
            tick();
            if (i >= 1 && i <= 5) begin
                chk("b2b_ce", CE, 1);
                chk("b2b_out", 32'(cur()), 32'(mk(8'h50 + 8'(i - 1), 8'hA0 + 8'(i - 1), 1'(i - 1), 4'(i - 1), 0, 2'b10)));
            end
        end
        chk("b2b_ce_end", CE, 0);
        exp_cnt += 5;
        chk("b2b_cnt", ISSUE_CNT, exp_cnt);
        // multiply stream fills the FIFO faster than it drains
        n = 0;
        saw = 0;
        for (int c = 0; c < 60 && n < 8; c++) begin
            drive(mk(8'hC0 + 8'(n), 8'h02, 0, 4'd9, 1, 2'b11), 1);
            if (!IN_READY) saw = 1;
            pushed = IN_READY;
            tick();
            if (pushed) n++;
        end
        drive(nop, 0);
        chk("full_seen", saw, 1);
        chk("full_pushed", n, 8);
        repeat (24) tick();
        exp_cnt += 8;
        chk("full_cnt", ISSUE_CNT, exp_cnt);
        chk("full_last", OPA, 8'hC7);
        // MUL followed by plain op: CE 1,0,1
        drive(mk(8'd64, 8'd63, 0, 4'd9, 1, 2'b11), 1);
        tick();
        drive(mk(8'd5, 8'd6, 0, 4'd4, 1, 2'b11), 1);
        tick();
        drive(nop, 0);
        chk("mul_ce1", CE, 1);
        chk("mul_opa1", OPA, 8'd64);
        tick();
        chk("mul_ce0", CE, 0);
        chk("mul_hold", OPA, 8'd64);
        tick();
        chk("mul_ce2", CE, 1);
        chk("mul_opa2", OPA, 8'd5);
        exp_cnt += 2;
        tick();
        // flush with three queued entries and a same-cycle push
        for (int i = 0; i < 5; i++) begin
            chk("fl_ready", IN_READY, 1);
            drive(mk(8'h30 + 8'(i), 8'h01, 0, 4'd9, 1, 2'b01), 1);
            tick();
        end
        drive(mk(8'h77, 8'h77, 0, 4'd1, 0, 2'b01), 1);
        FLUSH = 1;
        tick();
        FLUSH = 0;
        drive(nop, 0);
        exp_cnt += 2;
        chk("fl_ce", CE, 0);
        chk("fl_ready_after", IN_READY, 1);
        chk("fl_hold", 32'(cur()), 32'(mk(8'h31, 8'h01, 0, 4'd9, 1, 2'b01)));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fl_no_issue", CE, 0);
        end
        chk("fl_cnt", ISSUE_CNT, exp_cnt);
        // reset while in the multiply bubble
        drive(mk(8'h40, 8'h41, 1, 4'd10, 1, 2'b11), 1);
        tick();
        drive(nop, 0);
        tick();
        chk("rw_ce", CE, 1);
        tick();
        chk("rw_bubble", CE, 0);
        RST = 1;
        tick();
        RST = 0;
        chk("rw_out", 32'(cur()), 32'(0));
        chk("rw_ce0", CE, 0);
        chk("rw_cnt", ISSUE_CNT, 0);
`ifdef ALU_ISSUE_CHECK_EN
        drive(mk(8'h12, 8'h34, 0, 4'd12, 1, 2'b11), 1);
        tick();
        chk("drop1", DROP, 1);
        chk("drop1_ce", CE, 0);
        drive(mk(8'h12, 8'h34, 0, 4'd0, 0, 2'b00), 1);
        tick();
        drive(nop, 0);
        chk("drop2", DROP, 1);
        chk("drop2_ce", CE, 0);
        tick();
        chk("drop_end", DROP, 0);
        chk("drop_cnt", DROP_CNT, 2);
        chk("drop_no_issue", CE, 0);
`endif
        // randomized run against an issue-order scoreboard
        bl = 0;
        exp_cnt = 0;
        last = '0;
        for (int c = 0; c < 600; c++) begin
            r = rand_op();
            v = $urandom_range(0, 3) != 0;
            fl = $urandom_range(0, 40) == 0;
            drive(r, v);
            FLUSH = fl;
            chk("rnd_ready", IN_READY, q.size() < DEPTH);
            pushing = v && q.size() < DEPTH && !fl;
            avail = q.size();
            owe = bl;
            @(posedge CLK);
            if (fl) begin
                q.delete();
                bl = 0;
            end else if (pushing) q.push_back(r);
            @(negedge CLK);
            chk("rnd_ce", CE, !fl && avail > 0 && owe == 0);
            if (!fl && owe > 0) bl = owe - 1;
            if (CE && q.size() > 0) begin
                e = q.pop_front();
                chk("rnd_op", 32'(cur()), 32'(e));
                last = e;
                exp_cnt++;
                if (e.mode && (e.cmd == 4'd9 || e.cmd == 4'd10)) bl = MUL_GAP;
            end else chk("rnd_hold", 32'(cur()), 32'(last));
            chk("rnd_cnt", ISSUE_CNT, exp_cnt);
        end
        FLUSH = 0;
        drive(nop, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
